// File: rtl/conv_job_scheduler.sv
// Round-robin scheduler that streams one requester's IFM/weight words into a conv engine,
// routes the engine's results back to that requester and aborts the job if the engine stalls.
module conv_job_scheduler #(
    parameter int unsigned N_IFM   = 49,
    parameter int unsigned N_WGT   = 9,
    parameter int unsigned N_OFM   = 25,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [15:0] ifm_a,
    input  logic [15:0] ifm_b,
    input  logic [15:0] wgt_a,
    input  logic [15:0] wgt_b,
    output logic [1:0]  rd_en,
    output logic        eng_in_valid,
    output logic        eng_weight_valid,
    output logic [15:0] eng_ifm,
    output logic [15:0] eng_wgt,
    input  logic        eng_out_valid,
    input  logic [35:0] eng_ofm,
    output logic [1:0]  res_valid,
    output logic [35:0] res_data,
    output logic [1:0]  done,
    output logic        err,
    output logic        busy,
    output logic        owner
);

    localparam int unsigned LW = $clog2(N_IFM + 1);
    localparam int unsigned RW = $clog2(N_OFM + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    state;
    logic [LW-1:0] load_cnt;
    logic [RW-1:0] res_cnt;
    logic [TW-1:0] to_cnt;
    logic          last_owner;
    logic          err_flag;
    logic          grant;
    logic [1:0]    owner_oh;

    // On contention the requester that was not served last wins.
    assign grant    = (req == 2'b11) ? ~last_owner : req[1];
    assign owner_oh = owner ? 2'b10 : 2'b01;

    assign rd_en = (state == S_LOAD) ? owner_oh : 2'b00;
    assign done  = (state == S_DONE) ? owner_oh : 2'b00;
    assign err   = (state == S_DONE) && err_flag;
    assign busy  = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            load_cnt         <= '0;
            res_cnt          <= '0;
            to_cnt           <= '0;
            last_owner       <= 1'b1;
            err_flag         <= 1'b0;
            owner            <= 1'b0;
            eng_in_valid     <= 1'b0;
            eng_weight_valid <= 1'b0;
            eng_ifm          <= '0;
            eng_wgt          <= '0;
            res_valid        <= 2'b00;
            res_data         <= '0;
        end else begin
            eng_in_valid     <= 1'b0;
            eng_weight_valid <= 1'b0;
            res_valid        <= 2'b00;
            case (state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        state    <= S_LOAD;
                        owner    <= grant;
                        load_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    eng_in_valid     <= 1'b1;
                    eng_weight_valid <= (load_cnt < LW'(N_WGT));
                    eng_ifm          <= owner ? ifm_b : ifm_a;
                    eng_wgt          <= owner ? wgt_b : wgt_a;
                    load_cnt         <= load_cnt + 1'b1;
                    if (load_cnt == LW'(N_IFM - 1)) begin
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    state   <= S_WAIT;
                    res_cnt <= '0;
                    to_cnt  <= '0;
                end
                S_WAIT: begin
                    if (eng_out_valid) begin
                        res_data  <= eng_ofm;
                        res_valid <= owner_oh;
                        res_cnt   <= res_cnt + 1'b1;
                        to_cnt    <= '0;
                        if (res_cnt == RW'(N_OFM - 1)) begin
                            state <= S_DONE;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (to_cnt == TW'(TIMEOUT - 1)) begin
                            err_flag <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    last_owner <= owner;
                    err_flag   <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Scoreboard bench: stimulus pushes expected engine words, results and done pulses into queues;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_conv_job_scheduler;

    localparam int N_IFM   = 49;
    localparam int N_WGT   = 9;
    localparam int N_OFM   = 25;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] ifm_a, ifm_b, wgt_a, wgt_b;
    logic [1:0]  rd_en;
    logic        eng_in_valid, eng_weight_valid;
    logic [15:0] eng_ifm, eng_wgt;
    logic        eng_out_valid;
    logic [35:0] eng_ofm;
    logic [1:0]  res_valid;
    logic [35:0] res_data;
    logic [1:0]  done;
    logic        err, busy, owner;

    conv_job_scheduler #(
        .N_IFM(N_IFM), .N_WGT(N_WGT), .N_OFM(N_OFM), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req),
        .ifm_a(ifm_a), .ifm_b(ifm_b), .wgt_a(wgt_a), .wgt_b(wgt_b),
        .rd_en(rd_en), .eng_in_valid(eng_in_valid), .eng_weight_valid(eng_weight_valid),
        .eng_ifm(eng_ifm), .eng_wgt(eng_wgt), .eng_out_valid(eng_out_valid), .eng_ofm(eng_ofm),
        .res_valid(res_valid), .res_data(res_data), .done(done), .err(err), .busy(busy),
        .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] ifm; logic [15:0] wgt; logic wv; } eng_t;
    typedef struct { logic [1:0] v; logic [35:0] d; } res_t;
    typedef struct { logic [1:0] v; logic e; } done_t;

    eng_t       exp_eng[$];
    res_t       exp_res[$];
    done_t      exp_done[$];
    logic [1:0] done_log[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_model = 1;
    int cur_owner = 0;
    int load_len = 0;
    int last_res_cyc = 0;
    int res_seen = 0;
    logic [1:0] idle_req = 2'b00;

    always @(posedge clk) cyc++;

    function automatic logic [1:0] oh(input int k);
        return (k != 0) ? 2'b10 : 2'b01;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requesters always present fresh random words; the DUT picks them up on rd_en.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ifm_a = 16'($urandom);
            ifm_b = 16'($urandom);
            wgt_a = 16'($urandom);
            wgt_b = 16'($urandom);
        end
    end

    // Monitor: reference model of ownership, load length and the 1-cycle engine forwarding.
    initial begin
        eng_t  e;
        res_t  r;
        done_t d;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_model = 1;
                load_len   = 0;
                continue;
            end
            if (eng_in_valid) begin
                if (exp_eng.size() == 0) begin
                    check("eng_in_valid_unexpected", 1, 0);
                end else begin
                    e = exp_eng.pop_front();
                    check("eng_ifm", eng_ifm, e.ifm);
                    check("eng_wgt", eng_wgt, e.wgt);
                    check("eng_weight_valid", eng_weight_valid, e.wv);
                end
            end else if (eng_weight_valid) begin
                check("eng_weight_valid_alone", 1, 0);
            end
            if (rd_en != 2'b00) begin
                if (load_len == 0) begin
                    cur_owner = (idle_req == 2'b11) ? 1 - last_model : (idle_req[1] ? 1 : 0);
                end
                check("rd_en", rd_en, oh(cur_owner));
                e.ifm = (cur_owner != 0) ? ifm_b : ifm_a;
                e.wgt = (cur_owner != 0) ? wgt_b : wgt_a;
                e.wv  = (load_len < N_WGT);
                exp_eng.push_back(e);
                load_len++;
            end else if (load_len != 0) begin
                check("load_length", load_len, N_IFM);
                load_len = 0;
            end
            if (!busy) idle_req = req;
            if (res_valid != 2'b00) begin
                res_seen++;
                last_res_cyc = cyc;
                if (exp_res.size() == 0) begin
                    check("res_valid_unexpected", {res_valid, res_data}, 0);
                end else begin
                    r = exp_res.pop_front();
                    check("res_valid", res_valid, r.v);
                    check("res_data", res_data, r.d);
                end
            end
            if (done != 2'b00) begin
                done_log.push_back(done);
                if (exp_done.size() == 0) begin
                    check("done_unexpected", done, 0);
                end else begin
                    d = exp_done.pop_front();
                    check("done", done, d.v);
                    check("err", err, d.e);
                    if (d.e) check("timeout_distance", cyc - last_res_cyc, TIMEOUT);
                end
                last_model = cur_owner;
            end else if (err) begin
                check("err_without_done", 1, 0);
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_rd_en", rd_en, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_eng_in_valid", eng_in_valid, 0);
        check("rst_eng_weight_valid", eng_weight_valid, 0);
        check("rst_eng_ifm", eng_ifm, 0);
        check("rst_eng_wgt", eng_wgt, 0);
        check("rst_res_data", res_data, 0);
        check("rst_owner", owner, 0);
    endtask

    task automatic wait_in_valid(input logic lvl, input string name);
        int n = 0;
        while (eng_in_valid !== lvl && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check(name, 0, 1);
    endtask

    // One job: raise req, let the load run, then play the engine returning nres results.
    task automatic do_job(input logic [1:0] r, input int nres, input bit keep);
        int n0;
        int n;
        n0 = done_log.size();
        @(posedge clk);
        #1;
        req = r;
        @(negedge clk);
        wait_in_valid(1'b1, "wait_load_start");
        if (!keep) req = 2'b00;
        wait_in_valid(1'b0, "wait_load_end");
        for (int i = 0; i < nres; i++) begin
            int g;
            g = (i >= N_OFM) ? 0 : $urandom_range(0, 3);
            repeat (g) begin
                @(posedge clk);
                #1;
                eng_out_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            eng_out_valid = 1'b1;
            eng_ofm = {4'($urandom), $urandom};
            if (i < N_OFM) exp_res.push_back('{oh(cur_owner), eng_ofm});
            if (i == N_OFM - 1) exp_done.push_back('{oh(cur_owner), 1'b0});
        end
        @(posedge clk);
        #1;
        eng_out_valid = 1'b0;
        if (nres < N_OFM) exp_done.push_back('{oh(cur_owner), 1'b1});
        n = 0;
        while (done_log.size() == n0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("wait_done", 0, 1);
    endtask

    initial begin
        int n;
        int seen0;
        rst = 1'b1;
        req = 2'b00;
        eng_out_valid = 1'b0;
        eng_ofm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single job from A.
        do_job(2'b01, N_OFM, 1'b0);
        check("single_done_owner", done_log[done_log.size() - 1], 2'b01);

        // Spurious result while idle.
        seen0 = res_seen;
        @(posedge clk);
        #1;
        eng_out_valid = 1'b1;
        eng_ofm = 36'h123456789;
        @(posedge clk);
        #1;
        eng_out_valid = 1'b0;
        @(negedge clk);
        check("idle_spurious_busy", busy, 0);
        check("idle_spurious_res", res_seen, seen0);

        // Contention from reset: A, B, A.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = done_log.size();
        do_job(2'b11, N_OFM, 1'b1);
        do_job(2'b11, N_OFM, 1'b1);
        do_job(2'b11, N_OFM, 1'b1);
        req = 2'b00;
        if (done_log.size() >= n + 3) begin
            check("contention_1", done_log[n], 2'b01);
            check("contention_2", done_log[n + 1], 2'b10);
            check("contention_3", done_log[n + 2], 2'b01);
        end else begin
            check("contention_count", done_log.size() - n, 3);
        end

        // Timeout after 3 results from B.
        do_job(2'b10, 3, 1'b0);
        @(negedge clk);
        check("timeout_back_to_idle", busy, 0);

        // 26th result lands in DONE and must be dropped.
        seen0 = res_seen;
        do_job(2'b01, N_OFM + 1, 1'b0);
        repeat (2) @(negedge clk);
        check("extra_result_dropped", res_seen - seen0, N_OFM);
        check("extra_result_busy", busy, 0);

        // Reset at load count 20.
        @(posedge clk);
        #1;
        req = 2'b01;
        n = 0;
        while (load_len < 20 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("wait_load_20", 0, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 2'b00;
        #1;
        check_reset_outputs();
        exp_eng.delete();
        exp_res.delete();
        exp_done.delete();
        n = done_log.size();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("no_done_after_reset", done_log.size(), n);
        do_job(2'b10, N_OFM, 1'b0);
        check("post_reset_owner_b", done_log[done_log.size() - 1], 2'b10);

        repeat (3) @(negedge clk);
        check("queues_drained", exp_res.size() + exp_done.size() + exp_eng.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
